// File: rtl/trivium_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trivium_pkg
// Description : Shared types and constants for the Trivium output path.
//               The fifo_cnd_t codes are also used by the cipher core.
//               Contents:
//                 BLOCK_BYTES - bytes per cipher burst
//                 fifo_cnd_t  - back-pressure code to the cipher core
//                 buf_state_t - output buffer state
// Revision    : 1.0 - initial release
// ============================================================================
package trivium_pkg;

    localparam int BLOCK_BYTES = 256;

    typedef enum logic [1:0] {
        CND_READY   = 2'b00,
        CND_PARTIAL = 2'b01,
        CND_FULL    = 2'b10,
        CND_OVF     = 2'b11
    } fifo_cnd_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        ACTIVE   = 2'b01,
        FULL     = 2'b10,
        OVERFLOW = 2'b11
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/trivium_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : trivium_buf_ram
// Description : Simple dual-port DEPTH x DW RAM, synchronous write and
//               synchronous (registered) read. The read port is always
//               enabled.
// Ports       : clk       - clock, rising edge
//               i_wr_en   - write enable
//               i_wr_addr - write address
//               i_wr_data - write data
//               i_rd_addr - read address, sampled at the rising edge
//               o_rd_data - data at i_rd_addr from the previous edge
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_buf_ram #(
    parameter int DEPTH = 512,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/trivium_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : trivium_out_buffer
// Description : Circular byte buffer behind the Trivium cipher core. Captures
//               encrypted bursts, drains them over valid/ready with a
//               registered first-word-fall-through head, and reports
//               back-pressure to the core on fifo_cnd.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous reset, active high
//               stream    - encrypted byte from the cipher core
//               wt_sgn    - write strobe, one byte per cycle
//               flush     - synchronous clear of contents and error
//               clr_err   - clears the sticky overflow state only
//               fifo_cnd  - back-pressure code (see trivium_pkg::fifo_cnd_t)
//               out_data  - head byte
//               out_valid - out_data is valid
//               out_ready - consumer accepts out_data
//               out_last  - out_data is the final byte of its block
//               level     - bytes currently stored
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_out_buffer
    import trivium_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int BLOCK = BLOCK_BYTES,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          stream,
    input  logic                   wt_sgn,
    input  logic                   flush,
    input  logic                   clr_err,
    output logic [1:0]             fifo_cnd,
    output logic [DW-1:0]          out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_CW = $clog2(BLOCK);

    localparam logic [c_LW-1:0] c_DEPTH_L = c_LW'(DEPTH);
    localparam logic [c_LW-1:0] c_BLOCK_L = c_LW'(BLOCK);
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(BLOCK - 1);

    // Write/read counts carry one extra bit over the address so that a full
    // buffer (difference == DEPTH) is distinct from an empty one.
    logic [c_LW-1:0] r_wr_cnt;
    logic [c_LW-1:0] r_rd_cnt;
    logic [c_CW-1:0] r_byte_cnt;
    logic            r_valid;
    buf_state_t      r_state;
    buf_state_t      w_state_next;
    fifo_cnd_t       r_cnd;
    fifo_cnd_t       w_cnd_next;

    logic            w_clear;
    logic [c_LW-1:0] w_level;
    logic [c_LW-1:0] w_level_next;
    logic [c_LW-1:0] w_avail;
    logic [c_LW-1:0] w_free;
    logic [c_LW-1:0] w_rd_cnt_next;
    logic            w_full;
    logic            w_wr_en;
    logic            w_drop;
    logic            w_pop;
    logic [DW-1:0]   w_ram_q;

    assign w_clear       = rst | flush;
    assign w_level       = r_wr_cnt - r_rd_cnt;
    assign w_full        = (w_level == c_DEPTH_L);
    assign w_wr_en       = wt_sgn & ~w_full;
    // A write into a full buffer is lost even if a read frees a slot at the
    // same edge; the core was told not to write.
    assign w_drop        = wt_sgn & w_full;
    assign w_pop         = r_valid & out_ready;
    assign w_rd_cnt_next = r_rd_cnt + c_LW'(w_pop);
    assign w_level_next  = w_level + c_LW'(w_wr_en) - c_LW'(w_pop);
    // Bytes already in the RAM array after this edge's read; a byte written
    // at this same edge is not yet readable through the registered port.
    assign w_avail       = w_level - c_LW'(w_pop);
    assign w_free        = c_DEPTH_L - w_level;

    // The RAM is addressed with the post-pop read pointer so that its output
    // register holds the new head right after each handshake, and simply
    // re-reads the same head while the consumer stalls.
    trivium_buf_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (c_AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_cnt[c_AW-1:0]),
        .i_wr_data (stream),
        .i_rd_addr (w_rd_cnt_next[c_AW-1:0]),
        .o_rd_data (w_ram_q)
    );

    always_comb begin
        w_state_next = r_state;
        if (w_drop) begin
            w_state_next = OVERFLOW;
        end else if ((r_state == OVERFLOW) && !clr_err) begin
            w_state_next = OVERFLOW;
        end else if (w_level_next == '0) begin
            w_state_next = EMPTY;
        end else if (w_level_next == c_DEPTH_L) begin
            w_state_next = FULL;
        end else begin
            w_state_next = ACTIVE;
        end
    end

    // Derived from the registered state/level, so the code lags the causing
    // edge by one cycle.
    always_comb begin
        w_cnd_next = CND_READY;
        if (r_state == OVERFLOW) begin
            w_cnd_next = CND_OVF;
        end else if (r_state == FULL) begin
            w_cnd_next = CND_FULL;
        end else if (w_free < c_BLOCK_L) begin
            w_cnd_next = CND_PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_byte_cnt <= '0;
            r_valid    <= 1'b0;
            r_state    <= EMPTY;
            r_cnd      <= CND_READY;
        end else begin
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + c_LW'(1);
            end
            r_rd_cnt <= w_rd_cnt_next;
            if (w_pop) begin
                r_byte_cnt <= (r_byte_cnt == c_LAST) ? '0 : r_byte_cnt + c_CW'(1);
            end
            r_valid <= (w_avail != '0);
            r_state <= w_state_next;
            r_cnd   <= w_cnd_next;
        end
    end

    assign fifo_cnd  = r_cnd;
    assign out_valid = r_valid;
    assign out_data  = r_valid ? w_ram_q : '0;
    assign out_last  = r_valid && (r_byte_cnt == c_LAST);
    assign level     = w_level;

endmodule
`default_nettype wire

// File: tb/tb_trivium_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trivium_out_buffer
// Description : Scoreboard bench for trivium_out_buffer. Every accepted write
//               pushes {last, data} into a queue; a negedge monitor compares
//               the head against the DUT whenever out_valid is high and pops
//               on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trivium_out_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] stream;
    logic       wt_sgn;
    logic       flush;
    logic       clr_err;
    logic [1:0] fifo_cnd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [9:0] level;

    trivium_out_buffer #(
        .DEPTH (512),
        .BLOCK (256),
        .DW    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (stream),
        .wt_sgn    (wt_sgn),
        .flush     (flush),
        .clr_err   (clr_err),
        .fifo_cnd  (fifo_cnd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_fail = 0;
    int         wr_idx = 0;
    logic [7:0] wdata  = 8'h00;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n writes of the running data counter; accepted bytes go to the queue
    task automatic write_n(input int n, input bit accept);
        logic lst;
        for (int i = 0; i < n; i++) begin
            stream = wdata;
            wt_sgn = 1'b1;
            if (accept) begin
                lst = ((wr_idx % 256) == 255);
                exp_q.push_back({lst, wdata});
                wr_idx++;
            end
            wdata++;
            tick();
        end
        wt_sgn = 1'b0;
    endtask

    task automatic drain(input bit toggle_rdy);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
            if (toggle_rdy) out_ready = ~out_ready;
        end
        out_ready = 1'b0;
        chk("drain_done", exp_q.size(), 0);
        tick();
        tick();
        chk("drained_level", level, 0);
        chk("drained_valid", out_valid, 0);
    endtask

    // Monitor: head must match whenever valid (stall stability included)
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got data %0h last %0b, expected nothing", out_data, out_last);
            end else begin
                if ({out_last, out_data} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL out_byte: got last %0b data %0h, expected last %0b data %0h (t=%0t)",
                             out_last, out_data, exp_q[0][8], exp_q[0][7:0], $time);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stream = '0; wt_sgn = 1'b0; flush = 1'b0;
        clr_err = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_cnd", fifo_cnd, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);

        // 256 bytes 0x00..0xFF, no reads
        write_n(256, 1'b1);
        tick();
        chk("blk_level", level, 256);
        chk("blk_cnd", fifo_cnd, 2'b00);
        chk("blk_valid", out_valid, 1);
        chk("blk_head", out_data, 8'h00);
        drain(1'b0);

        // 257 bytes: free drops below BLOCK
        write_n(257, 1'b1);
        chk("w257_cnd_same_cycle", fifo_cnd, 2'b00);
        tick();
        chk("w257_cnd", fifo_cnd, 2'b01);
        chk("w257_level", level, 257);

        // fill to DEPTH
        write_n(255, 1'b1);
        tick();
        chk("full_level", level, 512);
        chk("full_cnd", fifo_cnd, 2'b10);

        // one write while full is dropped
        write_n(1, 1'b0);
        chk("ovf_level", level, 512);
        tick();
        chk("ovf_cnd", fifo_cnd, 2'b11);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_cnd_lag", fifo_cnd, 2'b11);
        tick();
        chk("clr_cnd", fifo_cnd, 2'b10);
        chk("clr_level", level, 512);
        drain(1'b0);

        // continuous write + read for 1024 cycles
        out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            stream = wdata;
            wt_sgn = 1'b1;
            exp_q.push_back({((wr_idx % 256) == 255), wdata});
            wr_idx++;
            wdata++;
            tick();
            if (i >= 3 && (i % 128) == 3) begin
                chk("stream_level", level, 2);
                chk("stream_cnd", fifo_cnd, 2'b00);
            end
        end
        wt_sgn = 1'b0;
        drain(1'b0);

        // 300 bytes, read 255 so the byte counter sits at BLOCK-1, then flush
        write_n(300, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        wr_idx = 0;
        chk("flush_level", level, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_cnd", fifo_cnd, 2'b00);
        wdata = 8'hA5;
        write_n(1, 1'b1);
        tick();
        chk("a5_valid", out_valid, 1);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_last", out_last, 0);
        drain(1'b0);

        // stall test: out_ready toggles every cycle
        write_n(256, 1'b1);
        drain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
